// File: rtl/memory_responder_ts_if.sv
// Handshake and decode signals between the CPU and the memory responder.
// The tri-state data bus stays a plain inout port on the responder.
interface memory_responder_ts_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ready;
    logic                  hit;
    logic                  protocol_error;

    modport master (
        output address, mem_read, mem_write,
        input  ready, hit, protocol_error
    );

    modport slave (
        input  address, mem_read, mem_write,
        output ready, hit, protocol_error
    );
endinterface

// File: rtl/memory_responder_ts.sv
// Word-addressed RAM answering the CPU's tri-state memory bus with a
// four-phase request/ready handshake and a programmable read latency.
module memory_responder_ts #(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DEPTH_LOG2   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    inout  wire  [DATA_WIDTH-1:0] data,
    memory_responder_ts_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [1:0] CNT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_ACK
    } state_t;

    state_t                state_q, state_n;
    logic [DEPTH_LOG2-1:0] idx_q, idx_n, addr_idx, rd_idx;
    logic [1:0]            cnt_q, cnt_n;
    logic                  err_q, err_n;
    logic                  ready_q, ready_n;
    logic                  wr_en, rd_load;
    logic                  hit, drive;
    logic                  unused_low;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    assign hit        = bus.address[ADDR_WIDTH-1:DEPTH_LOG2+3] == BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2+3];
    assign addr_idx   = bus.address[DEPTH_LOG2+2:3];
    assign unused_low = ^bus.address[2:0];

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
        wr_en   = 1'b0;
        rd_load = 1'b0;
        rd_idx  = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_read && bus.mem_write) begin
                    err_n = 1'b1;
                end else if (bus.mem_read && hit) begin
                    idx_n = addr_idx;
                    cnt_n = CNT_INIT;
                    if (READ_LATENCY == 1) begin
                        state_n = RD_DRIVE;
                        rd_load = 1'b1;
                        rd_idx  = addr_idx;
                    end else begin
                        state_n = RD_WAIT;
                    end
                end else if (bus.mem_write && hit) begin
                    idx_n   = addr_idx;
                    wr_en   = 1'b1;
                    state_n = WR_ACK;
                end
            end
            RD_WAIT: begin
                if (!bus.mem_read) begin
                    state_n = IDLE;
                end else if (cnt_q == 2'd0) begin
                    state_n = RD_DRIVE;
                    rd_load = 1'b1;
                end else begin
                    cnt_n = cnt_q - 2'd1;
                end
            end
            RD_DRIVE: begin
                if (!bus.mem_read) state_n = IDLE;
            end
            WR_ACK: begin
                if (!bus.mem_write) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == RD_DRIVE) || (state_n == WR_ACK);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
            ready_q <= ready_n;
        end
    end

    // Storage has no reset; the write strobe is still gated so a reset edge never commits a write.
    always_ff @(posedge clock) begin
        if (reset && wr_en) mem[idx_n] <= data;
        if (reset && rd_load) rdata_q <= mem[rd_idx];
    end

    // Release is combinational so the bus frees in the same cycle mem_read falls.
    assign drive = (state_q == RD_DRIVE) && bus.mem_read;
    assign data  = drive ? rdata_q : 'z;

    assign bus.ready          = ready_q;
    assign bus.hit            = hit;
    assign bus.protocol_error = err_q;
endmodule

// File: tb/tb_memory_responder_ts.sv
// Directed checks of memory_responder_ts at read latencies 1, 3 and 4.
// Data buses carry pull-ups, so a released bus reads all ones.
module tb_memory_responder_ts;
    localparam logic [63:0] REL = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] W10 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] W18 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] W00 = 64'h0F0F_0F0F_0F0F_0F0F;
    localparam logic [63:0] W20 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W40 = 64'hCAFE_F00D_1234_5678;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr [3];
    logic        rd   [3];
    logic        wr   [3];
    logic        tdrv [3];
    logic [63:0] tval [3];
    int          n_cmp = 0;
    int          n_err = 0;

    wire [63:0] d1, d3, d4;
    pullup (d1);
    pullup (d3);
    pullup (d4);
    assign d1 = tdrv[0] ? tval[0] : 'z;
    assign d3 = tdrv[1] ? tval[1] : 'z;
    assign d4 = tdrv[2] ? tval[2] : 'z;

    memory_responder_ts_if #(.ADDR_WIDTH(32)) b1 ();
    memory_responder_ts_if #(.ADDR_WIDTH(32)) b3 ();
    memory_responder_ts_if #(.ADDR_WIDTH(32)) b4 ();
    assign b1.address = addr[0];  assign b1.mem_read = rd[0];  assign b1.mem_write = wr[0];
    assign b3.address = addr[1];  assign b3.mem_read = rd[1];  assign b3.mem_write = wr[1];
    assign b4.address = addr[2];  assign b4.mem_read = rd[2];  assign b4.mem_write = wr[2];

    memory_responder_ts #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH_LOG2(8),
        .BASE_ADDR(32'h0), .READ_LATENCY(1)) dut1 (.clock(clock), .reset(reset), .data(d1), .bus(b1));
    memory_responder_ts #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH_LOG2(8),
        .BASE_ADDR(32'h0), .READ_LATENCY(3)) dut3 (.clock(clock), .reset(reset), .data(d3), .bus(b3));
    memory_responder_ts #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH_LOG2(8),
        .BASE_ADDR(32'h0), .READ_LATENCY(4)) dut4 (.clock(clock), .reset(reset), .data(d4), .bus(b4));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Write one word on instance k, checking the one-edge acknowledge.
    task automatic do_write(input int k, input logic [31:0] a, input logic [63:0] v, input string tag);
        logic r;
        addr[k] = a; wr[k] = 1'b1; tdrv[k] = 1'b1; tval[k] = v;
        step();
        r = (k == 0) ? b1.ready : (k == 1) ? b3.ready : b4.ready;
        chk(tag, {63'd0, r}, 64'd1);
        wr[k] = 1'b0; tdrv[k] = 1'b0;
        step();
    endtask

    // Latency-1 read on instance 0: ready and data one edge after the request.
    task automatic read1(input logic [31:0] a, input logic [63:0] v, input string tag);
        addr[0] = a; rd[0] = 1'b1;
        step();
        chk({tag, "_rdy"}, {63'd0, b1.ready}, 64'd1);
        chk({tag, "_dat"}, d1, v);
        rd[0] = 1'b0;
        #1;
        chk({tag, "_rel"}, d1, REL);
        step();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0; tdrv[i] = 1'b0; tval[i] = '0;
        end
        step(); step();
        chk("rst_ready1", {63'd0, b1.ready}, 64'd0);
        chk("rst_ready3", {63'd0, b3.ready}, 64'd0);
        chk("rst_perr1", {63'd0, b1.protocol_error}, 64'd0);
        chk("rst_bus1", d1, REL);
        chk("rst_bus4", d4, REL);
        reset = 1'b1;
        step();

        // Write / read at latency 1, including ignored low address bits
        addr[0] = 32'h10;
        #1;
        chk("hit_0x10", {63'd0, b1.hit}, 64'd1);
        do_write(0, 32'h10, W10, "wr10_ack");
        chk("wr10_drop", {63'd0, b1.ready}, 64'd0);
        do_write(0, 32'h18, W18, "wr18_ack");
        do_write(0, 32'h00, W00, "wr00_ack");
        addr[0] = 32'h10; rd[0] = 1'b1;
        #1;
        chk("rd10_pre_rdy", {63'd0, b1.ready}, 64'd0);
        chk("rd10_pre_bus", d1, REL);
        rd[0] = 1'b0;
        read1(32'h10, W10, "rd10");
        read1(32'h17, W10, "rd17");
        read1(32'h18, W18, "rd18");

        // Address moves during RD_DRIVE: latched index keeps being served
        addr[0] = 32'h10; rd[0] = 1'b1;
        step();
        addr[0] = 32'h18;
        #1;
        chk("latched_idx", d1, W10);
        rd[0] = 1'b0;
        step();

        // Miss: never ready, never drives, write is dropped
        addr[0] = 32'h800; rd[0] = 1'b1;
        #1;
        chk("miss_hit", {63'd0, b1.hit}, 64'd0);
        step(); step();
        chk("miss_rd_rdy", {63'd0, b1.ready}, 64'd0);
        chk("miss_rd_bus", d1, REL);
        rd[0] = 1'b0; wr[0] = 1'b1; tdrv[0] = 1'b1; tval[0] = 64'hAAAA_5555_AAAA_5555;
        step();
        chk("miss_wr_rdy", {63'd0, b1.ready}, 64'd0);
        wr[0] = 1'b0; tdrv[0] = 1'b0;
        step();
        read1(32'h00, W00, "miss_keep00");
        read1(32'h10, W10, "miss_keep10");

        // Simultaneous read and write: sticky protocol_error, no access
        addr[0] = 32'h10; rd[0] = 1'b1; wr[0] = 1'b1;
        step();
        chk("perr_set", {63'd0, b1.protocol_error}, 64'd1);
        chk("perr_rdy", {63'd0, b1.ready}, 64'd0);
        chk("perr_bus", d1, REL);
        rd[0] = 1'b0; wr[0] = 1'b0;
        step();
        read1(32'h18, W18, "perr_then_rd");
        chk("perr_sticky", {63'd0, b1.protocol_error}, 64'd1);

        // Latency 3
        do_write(1, 32'h20, W20, "l3_wr_ack");
        addr[1] = 32'h20; rd[1] = 1'b1;
        step();
        chk("l3_e1_rdy", {63'd0, b3.ready}, 64'd0);
        chk("l3_e1_bus", d3, REL);
        step();
        chk("l3_e2_rdy", {63'd0, b3.ready}, 64'd0);
        chk("l3_e2_bus", d3, REL);
        step();
        chk("l3_e3_rdy", {63'd0, b3.ready}, 64'd1);
        chk("l3_e3_dat", d3, W20);
        rd[1] = 1'b0;
        #1;
        chk("l3_release", d3, REL);
        step();
        chk("l3_rdy_drop", {63'd0, b3.ready}, 64'd0);

        // Latency 4: abort after two cycles, then a full read
        do_write(2, 32'h40, W40, "l4_wr_ack");
        addr[2] = 32'h40; rd[2] = 1'b1;
        step(); step();
        rd[2] = 1'b0;
        step();
        chk("l4_abort_rdy", {63'd0, b4.ready}, 64'd0);
        chk("l4_abort_bus", d4, REL);
        step();
        chk("l4_abort_rdy2", {63'd0, b4.ready}, 64'd0);
        rd[2] = 1'b1;
        step(); step(); step();
        chk("l4_e3_rdy", {63'd0, b4.ready}, 64'd0);
        step();
        chk("l4_e4_rdy", {63'd0, b4.ready}, 64'd1);
        chk("l4_e4_dat", d4, W40);
        rd[2] = 1'b0;
        step();

        // Reset during RD_DRIVE abandons the read, memory survives
        addr[0] = 32'h10; rd[0] = 1'b1;
        step();
        chk("rstrd_rdy", {63'd0, b1.ready}, 64'd1);
        reset = 1'b0;
        step();
        chk("rstrd_rdy0", {63'd0, b1.ready}, 64'd0);
        chk("rstrd_bus", d1, REL);
        chk("rstrd_perr", {63'd0, b1.protocol_error}, 64'd0);
        reset = 1'b1; rd[0] = 1'b0;
        step();
        read1(32'h10, W10, "post_rst10");
        read1(32'h18, W18, "post_rst18");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
